// File: rtl/ddr3_user_port_arbiter.sv
// Two-port round-robin arbiter sharing the ddr3_memory_controller user command path.
// Each granted command is held until the controller accepts it. Read data returns in order
// and is routed back to the port that issued the read, using a small tag FIFO.
// Optional build macro: ARB_FIXED_PRIORITY_EN (port 0 always wins when both are eligible).
module ddr3_user_port_arbiter #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DQ_W         = 16,
  parameter int unsigned RD_TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DQ_W-1:0]   p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DQ_W-1:0]   p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DQ_W-1:0]   rdata,
  output logic              write_enable,
  output logic              read_enable,
  output logic [ADDR_W-1:0] i_user_data_address,
  output logic [DQ_W-1:0]   data_to_ram,
  input  logic              ctl_accept,
  input  logic              ctl_rd_valid,
  input  logic [DQ_W-1:0]   data_from_ram,
  output logic              rd_err
);

  localparam int unsigned PtrW = $clog2(RD_TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(RD_TAG_DEPTH);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                last_grant_q, last_grant_d;
  logic                write_enable_q, write_enable_d;
  logic                read_enable_q, read_enable_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DQ_W-1:0]     wdata_q, wdata_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic [DQ_W-1:0]     rdata_q, rdata_d;
  logic                rd_err_q, rd_err_d;
  logic [RD_TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic pick1;
  logic push;
  logic pop;

  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == '0);

  // A read cannot be granted while every tag slot is still waiting for its data.
  assign elig0 = p0_req && (p0_we || !fifo_full);
  assign elig1 = p1_req && (p1_we || !fifo_full);

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick1 = !elig0;
`else
  // On a tie the port that did not win last time goes first.
  assign pick1 = elig1 && (!elig0 || !last_grant_q);
`endif

  // Arbitration FSM: grant in idle, hold the command until the controller accepts it.
  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    last_grant_d   = last_grant_q;
    write_enable_d = write_enable_q;
    read_enable_d  = read_enable_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    p0_ack_d       = 1'b0;
    p1_ack_d       = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          win_d          = pick1;
          write_enable_d = pick1 ? p1_we : p0_we;
          read_enable_d  = pick1 ? !p1_we : !p0_we;
          addr_d         = pick1 ? p1_addr : p0_addr;
          wdata_d        = pick1 ? p1_wdata : p0_wdata;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        if (ctl_accept) begin
          write_enable_d = 1'b0;
          read_enable_d  = 1'b0;
          p0_ack_d       = !win_q;
          p1_ack_d       = win_q;
          last_grant_d   = win_q;
          push           = read_enable_q;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read tag FIFO: push the winner on each accepted read, pop and route on each return.
  always_comb begin
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rd_err_d    = rd_err_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    pop         = 1'b0;
    if (ctl_rd_valid) begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        rdata_d     = data_from_ram;
        p0_rvalid_d = !tag_q[rd_ptr_q];
        p1_rvalid_d = tag_q[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + PtrW'(1);
      end else begin
        // Data with nobody waiting for it: drop it and remember the protocol error.
        rd_err_d = 1'b1;
      end
    end
    if (push) begin
      tag_d[wr_ptr_q] = win_q;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset abandons any in-flight command and empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      win_q          <= 1'b0;
      last_grant_q   <= 1'b1;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      p0_ack_q       <= 1'b0;
      p1_ack_q       <= 1'b0;
      p0_rvalid_q    <= 1'b0;
      p1_rvalid_q    <= 1'b0;
      rdata_q        <= '0;
      rd_err_q       <= 1'b0;
      tag_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      win_q          <= win_d;
      last_grant_q   <= last_grant_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      p0_ack_q       <= p0_ack_d;
      p1_ack_q       <= p1_ack_d;
      p0_rvalid_q    <= p0_rvalid_d;
      p1_rvalid_q    <= p1_rvalid_d;
      rdata_q        <= rdata_d;
      rd_err_q       <= rd_err_d;
      tag_q          <= tag_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign p0_ack              = p0_ack_q;
  assign p1_ack              = p1_ack_q;
  assign p0_rvalid           = p0_rvalid_q;
  assign p1_rvalid           = p1_rvalid_q;
  assign rdata               = rdata_q;
  assign write_enable        = write_enable_q;
  assign read_enable         = read_enable_q;
  assign i_user_data_address = addr_q;
  assign data_to_ram         = wdata_q;
  assign rd_err              = rd_err_q;

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Self-checking bench for ddr3_user_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference (grant rule, tag queue, sticky error).
module tb_ddr3_user_port_arbiter;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DQ_W   = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DQ_W-1:0]   p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DQ_W-1:0]   rdata;
  logic              write_enable, read_enable;
  logic [ADDR_W-1:0] i_user_data_address;
  logic [DQ_W-1:0]   data_to_ram;
  logic              ctl_accept, ctl_rd_valid;
  logic [DQ_W-1:0]   data_from_ram;
  logic              rd_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ddr3_user_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DQ_W        (DQ_W),
    .RD_TAG_DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .p0_req             (p0_req),
    .p0_we              (p0_we),
    .p0_addr            (p0_addr),
    .p0_wdata           (p0_wdata),
    .p1_req             (p1_req),
    .p1_we              (p1_we),
    .p1_addr            (p1_addr),
    .p1_wdata           (p1_wdata),
    .p0_ack             (p0_ack),
    .p1_ack             (p1_ack),
    .p0_rvalid          (p0_rvalid),
    .p1_rvalid          (p1_rvalid),
    .rdata              (rdata),
    .write_enable       (write_enable),
    .read_enable        (read_enable),
    .i_user_data_address(i_user_data_address),
    .data_to_ram        (data_to_ram),
    .ctl_accept         (ctl_accept),
    .ctl_rd_valid       (ctl_rd_valid),
    .data_from_ram      (data_from_ram),
    .rd_err             (rd_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    ctl_accept = 0; ctl_rd_valid = 0; data_from_ram = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  // Presents one command on a port and accepts it once enabled; reports which ack pulsed.
  task automatic issue(input int port, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DQ_W-1:0] d, output int acked);
    logic en;
    if (port == 0) begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
    en = 0;
    for (int i = 0; i < 8 && !en; i++) begin
      step();
      en = write_enable | read_enable;
    end
    acked = -1;
    if (en) begin
      ctl_accept = 1;
      step();
      ctl_accept = 0;
      if (p0_ack && !p1_ack) acked = 0;
      else if (p1_ack && !p0_ack) acked = 1;
    end
    if (port == 0) p0_req = 0; else p1_req = 0;
  endtask

  task automatic test_reset();
    logic [3*DQ_W+ADDR_W+6:0] outs;
    clear_inputs();
    p0_req = 1; p1_req = 1; p0_we = 1; p1_we = 1;
    p0_addr = 18'h10; p1_addr = 18'h20; p0_wdata = 16'h1111; p1_wdata = 16'h2222;
    ctl_accept = 1; ctl_rd_valid = 1; data_from_ram = 16'hFFFF;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      outs = {write_enable, read_enable, p0_ack, p1_ack, p0_rvalid, p1_rvalid, rdata,
              i_user_data_address, data_to_ram, rd_err, 16'h0};
      n_total++;
      if (outs !== '0) $display("FAIL reset_outputs cyc%0d: got %h want 0", i, outs);
      else n_pass++;
    end
    ctl_accept = 0; ctl_rd_valid = 0; reset = 0;
    step();
    n_total++;
    if ({write_enable, read_enable} !== 2'b10)
      $display("FAIL first_enable: got we=%b re=%b want we=1 re=0", write_enable, read_enable);
    else n_pass++;
    n_total++;
    if ({i_user_data_address, data_to_ram} !== {18'h10, 16'h1111})
      $display("FAIL first_grant_cmd: got %h/%h want 10/1111", i_user_data_address, data_to_ram);
    else n_pass++;
    ctl_accept = 1;
    step();
    ctl_accept = 0;
    n_total++;
    if ({p1_ack, p0_ack, write_enable} !== 3'b010)
      $display("FAIL first_ack: got p1=%b p0=%b we=%b want 0 1 0", p1_ack, p0_ack, write_enable);
    else n_pass++;
  endtask

  // Both ports request writes continuously.
  task automatic test_round_robin();
    int exp_port;
    int p0_cnt = 0;
    do_reset();
    p0_req = 1; p1_req = 1; p0_we = 1; p1_we = 1;
    p0_addr = 18'h10; p1_addr = 18'h20; p0_wdata = 16'h1111; p1_wdata = 16'h2222;
    step();
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_port = 0;
`else
      exp_port = i % 2;
`endif
      n_total++;
      if (write_enable !== 1'b1 || i_user_data_address !== (exp_port == 1 ? 18'h20 : 18'h10))
        $display("FAIL arb_cmd%0d: got en=%b addr=%h want en=1 addr=%h", i, write_enable,
                 i_user_data_address, exp_port == 1 ? 18'h20 : 18'h10);
      else n_pass++;
      ctl_accept = 1;
      step();
      ctl_accept = 0;
      if (p0_ack) p0_cnt++;
      n_total++;
      if ({p1_ack, p0_ack} !== (exp_port == 1 ? 2'b10 : 2'b01))
        $display("FAIL arb_ack%0d: got p1=%b p0=%b want port %0d", i, p1_ack, p0_ack, exp_port);
      else n_pass++;
      step();
    end
`ifdef ARB_FIXED_PRIORITY_EN
    n_total++;
    if (p0_cnt !== 4) $display("FAIL fixed_p0_count: got %0d want 4", p0_cnt);
    else n_pass++;
`endif
    clear_inputs();
  endtask

  task automatic test_read_routing();
    int acked;
    logic [DQ_W-1:0] dat [3] = '{16'hA1, 16'hA2, 16'hB1};
    logic [1:0]      who [3] = '{2'b01, 2'b01, 2'b10};
    do_reset();
    issue(0, 0, 18'h100, '0, acked);
    n_total++; if (acked !== 0) $display("FAIL rd_ack0: got %0d want 0", acked); else n_pass++;
    issue(0, 0, 18'h101, '0, acked);
    n_total++; if (acked !== 0) $display("FAIL rd_ack1: got %0d want 0", acked); else n_pass++;
    issue(1, 0, 18'h200, '0, acked);
    n_total++; if (acked !== 1) $display("FAIL rd_ack2: got %0d want 1", acked); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      ctl_rd_valid = 1; data_from_ram = dat[i];
      step();
      n_total++;
      if ({p1_rvalid, p0_rvalid} !== who[i] || rdata !== dat[i])
        $display("FAIL rd_return%0d: got rv=%b data=%h want rv=%b data=%h", i,
                 {p1_rvalid, p0_rvalid}, rdata, who[i], dat[i]);
      else n_pass++;
    end
    ctl_rd_valid = 0; data_from_ram = 16'hDEAD;
    step();
    n_total++;
    if ({p1_rvalid, p0_rvalid} !== 2'b00 || rdata !== 16'hB1)
      $display("FAIL rd_hold: got rv=%b data=%h want rv=00 data=00b1", {p1_rvalid, p0_rvalid},
               rdata);
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    int acked;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(i % 2, 0, ADDR_W'(18'h30 + i), '0, acked);
      n_total++;
      if (acked !== i % 2) $display("FAIL fill_ack%0d: got %0d want %0d", i, acked, i % 2);
      else n_pass++;
    end
    p0_req = 1; p0_we = 0; p0_addr = 18'h300;
    p1_req = 1; p1_we = 1; p1_addr = 18'h301; p1_wdata = 16'h4242;
    step();
    n_total++;
    if ({write_enable, read_enable} !== 2'b10 || i_user_data_address !== 18'h301)
      $display("FAIL full_write_grant: got we=%b re=%b addr=%h want 1 0 301", write_enable,
               read_enable, i_user_data_address);
    else n_pass++;
    ctl_accept = 1;
    step();
    ctl_accept = 0; p1_req = 0;
    n_total++;
    if ({p1_ack, p0_ack} !== 2'b10) $display("FAIL full_write_ack: got %b want 10", {p1_ack, p0_ack});
    else n_pass++;
    step();
    step();
    n_total++;
    if (read_enable !== 1'b0) $display("FAIL full_read_blocked: got re=%b want 0", read_enable);
    else n_pass++;
    ctl_rd_valid = 1; data_from_ram = 16'hC0;
    step();
    ctl_rd_valid = 0;
    n_total++;
    if ({p1_rvalid, p0_rvalid} !== 2'b01 || rdata !== 16'hC0)
      $display("FAIL full_pop: got rv=%b data=%h want 01 00c0", {p1_rvalid, p0_rvalid}, rdata);
    else n_pass++;
    step();
    n_total++;
    if (read_enable !== 1'b1 || i_user_data_address !== 18'h300)
      $display("FAIL full_read_grant: got re=%b addr=%h want 1 300", read_enable,
               i_user_data_address);
    else n_pass++;
    ctl_accept = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_rd_err_and_reset();
    int acked;
    do_reset();
    ctl_rd_valid = 1; data_from_ram = 16'h5555;
    step();
    ctl_rd_valid = 0;
    n_total++;
    if ({p1_rvalid, p0_rvalid} !== 2'b00 || rdata !== '0 || rd_err !== 1'b1)
      $display("FAIL empty_pop: got rv=%b data=%h err=%b want 00 0000 1",
               {p1_rvalid, p0_rvalid}, rdata, rd_err);
    else n_pass++;
    issue(1, 0, 18'h40, '0, acked);
    n_total++;
    if (acked !== 1 || rd_err !== 1'b1)
      $display("FAIL err_sticky: got ack=%0d err=%b want 1 1", acked, rd_err);
    else n_pass++;
    p0_req = 1; p0_we = 1; p0_addr = 18'h50;
    step();
    n_total++;
    if (write_enable !== 1'b1) $display("FAIL issue_before_reset: got we=%b want 1", write_enable);
    else n_pass++;
    reset = 1; ctl_accept = 1;
    step();
    reset = 0; ctl_accept = 0; p0_req = 0;
    n_total++;
    if ({p1_ack, p0_ack, write_enable, read_enable, rd_err} !== 5'b0)
      $display("FAIL reset_in_issue: got acks=%b en=%b err=%b want 0", {p1_ack, p0_ack},
               {write_enable, read_enable}, rd_err);
    else n_pass++;
    ctl_rd_valid = 1; data_from_ram = 16'h7777;
    step();
    ctl_rd_valid = 0;
    n_total++;
    if ({p1_rvalid, p0_rvalid} !== 2'b00 || rd_err !== 1'b1 || rdata !== '0)
      $display("FAIL fifo_cleared: got rv=%b err=%b data=%h want 00 1 0000",
               {p1_rvalid, p0_rvalid}, rd_err, rdata);
    else n_pass++;
  endtask

  // Random traffic against a transaction-level model of grants, acks and tag routing.
  task automatic test_random();
    logic            r_req [2];
    logic            r_we  [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic [DQ_W-1:0] r_wd  [2];
    int              m_tags[$];
    bit              m_busy = 0;
    int              m_win = 0;
    int              m_last = 1;
    logic [DQ_W-1:0] m_rdata = '0;
    logic [1:0]      e_ack, e_rv, e_en;
    bit              el0, el1, push_rd;
    int              t;
    do_reset();
    for (int p = 0; p < 2; p++) r_req[p] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++)
        if (!r_req[p] && $urandom_range(0, 2) == 0) begin
          r_req[p] = 1; r_we[p] = 1'($urandom_range(0, 1));
          r_addr[p] = ADDR_W'($urandom); r_wd[p] = DQ_W'($urandom);
        end
      ctl_accept    = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      ctl_rd_valid  = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
      data_from_ram = DQ_W'($urandom);
      p0_req = r_req[0]; p0_we = r_we[0]; p0_addr = r_addr[0]; p0_wdata = r_wd[0];
      p1_req = r_req[1]; p1_we = r_we[1]; p1_addr = r_addr[1]; p1_wdata = r_wd[1];
      e_ack = 0; e_rv = 0; push_rd = 0;
      el0 = r_req[0] && (r_we[0] || m_tags.size() < DEPTH);
      el1 = r_req[1] && (r_we[1] || m_tags.size() < DEPTH);
      if (!m_busy) begin
        if (el0 || el1) begin
`ifdef ARB_FIXED_PRIORITY_EN
          m_win = el0 ? 0 : 1;
`else
          m_win = (el0 && el1) ? 1 - m_last : (el0 ? 0 : 1);
`endif
          m_busy = 1;
        end
      end else if (ctl_accept) begin
        e_ack[m_win] = 1; m_last = m_win; push_rd = !r_we[m_win]; m_busy = 0;
      end
      if (ctl_rd_valid) begin
        t = m_tags.pop_front();
        e_rv[t] = 1; m_rdata = data_from_ram;
      end
      if (push_rd) m_tags.push_back(m_win);
      step();
      e_en = m_busy ? (r_we[m_win] ? 2'b10 : 2'b01) : 2'b00;
      n_total++;
      if ({write_enable, read_enable} !== e_en)
        $display("FAIL rnd_enable cyc%0d: got %b want %b", cyc, {write_enable, read_enable}, e_en);
      else n_pass++;
      if (m_busy) begin
        n_total++;
        if (i_user_data_address !== r_addr[m_win] || (r_we[m_win] && data_to_ram !== r_wd[m_win]))
          $display("FAIL rnd_cmd cyc%0d: got %h/%h want %h/%h", cyc, i_user_data_address,
                   data_to_ram, r_addr[m_win], r_wd[m_win]);
        else n_pass++;
      end
      n_total++;
      if ({p1_ack, p0_ack} !== e_ack)
        $display("FAIL rnd_ack cyc%0d: got %b want %b", cyc, {p1_ack, p0_ack}, e_ack);
      else n_pass++;
      n_total++;
      if ({p1_rvalid, p0_rvalid} !== e_rv || rdata !== m_rdata || rd_err !== 1'b0)
        $display("FAIL rnd_rdata cyc%0d: got rv=%b data=%h err=%b want rv=%b data=%h err=0",
                 cyc, {p1_rvalid, p0_rvalid}, rdata, rd_err, e_rv, m_rdata);
      else n_pass++;
      for (int p = 0; p < 2; p++) if (e_ack[p]) r_req[p] = 0;
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_read_routing();
    test_fifo_full();
    test_rd_err_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
